// File: rtl/fb_access_ctrl_if.sv
// Command/response bundle between the SPI command decoder (master) and the
// framebuffer/palette access sequencer (slave).
interface fb_access_ctrl_if;
  // A command transfers on a clk edge where cmd_valid && cmd_ready. cmd_* hold
  // their values while cmd_valid is high. rsp_valid and done are one-cycle
  // strobes with no backpressure; the master must take them when they occur.
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [23:0] cmd_data;
  logic        cmd_sync;
  logic        rsp_valid;
  logic [23:0] rsp_data;
  logic        done;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_data, cmd_sync,
    input  cmd_ready, rsp_valid, rsp_data, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_data, cmd_sync,
    output cmd_ready, rsp_valid, rsp_data, done
  );
endinterface

// File: rtl/fb_access_ctrl.sv
// Sequencer for the SPI-side framebuffer and palette RAM ports: pixel/palette
// reads and writes plus clipped rectangle fills, optionally deferred to vblank.
module fb_access_ctrl #(
  parameter int FRAME_WIDTH  = 320,
  parameter int FRAME_HEIGHT = 240,
  parameter int ADDR_W       = 17
) (
  input  logic              clk,
  input  logic              reset,
  fb_access_ctrl_if.slave   bus,
  input  logic              vblank,
  output logic [ADDR_W-1:0] rgb_addr,
  output logic [7:0]        rgb_wdata,
  output logic              wren_rgb,
  input  logic [7:0]        rgb_rdata,
  output logic [7:0]        pal_addr,
  output logic [23:0]       pal_wdata,
  output logic              wren_pal,
  input  logic [23:0]       pal_rdata,
  output logic [2:0]        state_dbg
);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_CAP, WAIT_VB, FILL} state_e;

  localparam logic [2:0] OP_WR_PIX = 3'd0;
  localparam logic [2:0] OP_RD_PIX = 3'd1;
  localparam logic [2:0] OP_FILL   = 3'd2;
  localparam logic [2:0] OP_WR_PAL = 3'd3;
  localparam logic [2:0] OP_RD_PAL = 3'd4;

  state_e state, state_n;
  logic [ADDR_W-1:0] rgb_addr_n, row_base, row_base_n;
  logic [7:0]  rgb_wdata_n, pal_addr_n, fill_h, fill_h_n, row, row_n;
  logic [23:0] pal_wdata_n, rsp_data_q, rsp_data_n;
  logic [8:0]  fill_w, fill_w_n, col, col_n;
  logic        wren_rgb_n, wren_pal_n, rsp_valid_q, rsp_valid_n, done_q, done_n;
  logic        rd_pal, rd_pal_n, rd_oor, rd_oor_n, fill_end, fill_end_n, vb_q;

  // Decode of the presented command; only meaningful while in IDLE.
  logic              x_ok, y_ok;
  logic [8:0]        w_room, w_eff;
  logic [7:0]        h_room, h_eff;
  logic [ADDR_W-1:0] pix_addr;

  assign x_ok     = bus.cmd_x < 9'(FRAME_WIDTH);
  assign y_ok     = bus.cmd_y < 8'(FRAME_HEIGHT);
  assign w_room   = 9'(FRAME_WIDTH) - bus.cmd_x;
  assign h_room   = 8'(FRAME_HEIGHT) - bus.cmd_y;
  assign w_eff    = (bus.cmd_w < w_room) ? bus.cmd_w : w_room;
  assign h_eff    = (bus.cmd_h < h_room) ? bus.cmd_h : h_room;
  assign pix_addr = ADDR_W'(bus.cmd_y) * ADDR_W'(FRAME_WIDTH) + ADDR_W'(bus.cmd_x);

  assign bus.cmd_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.done      = done_q;
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rgb_addr  <= '0;
      rgb_wdata <= '0;
      wren_rgb  <= 1'b0;
      pal_addr  <= '0;
      pal_wdata <= '0;
      wren_pal  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      done_q    <= 1'b0;
      rd_pal    <= 1'b0;
      rd_oor    <= 1'b0;
      fill_w    <= '0;
      fill_h    <= '0;
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      fill_end  <= 1'b0;
      vb_q      <= 1'b0;
    end else begin
      state     <= state_n;
      rgb_addr  <= rgb_addr_n;
      rgb_wdata <= rgb_wdata_n;
      wren_rgb  <= wren_rgb_n;
      pal_addr  <= pal_addr_n;
      pal_wdata <= pal_wdata_n;
      wren_pal  <= wren_pal_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_data_q  <= rsp_data_n;
      done_q    <= done_n;
      rd_pal    <= rd_pal_n;
      rd_oor    <= rd_oor_n;
      fill_w    <= fill_w_n;
      fill_h    <= fill_h_n;
      col       <= col_n;
      row       <= row_n;
      row_base  <= row_base_n;
      fill_end  <= fill_end_n;
      vb_q      <= vblank;
    end
  end

  always_comb begin
    state_n     = state;
    rgb_addr_n  = rgb_addr;
    rgb_wdata_n = rgb_wdata;
    wren_rgb_n  = 1'b0;
    pal_addr_n  = pal_addr;
    pal_wdata_n = pal_wdata;
    wren_pal_n  = 1'b0;
    rsp_valid_n = 1'b0;
    rsp_data_n  = rsp_data_q;
    done_n      = 1'b0;
    rd_pal_n    = rd_pal;
    rd_oor_n    = rd_oor;
    fill_w_n    = fill_w;
    fill_h_n    = fill_h;
    col_n       = col;
    row_n       = row;
    row_base_n  = row_base;
    fill_end_n  = fill_end;
    case (state)
      IDLE: if (bus.cmd_valid) begin
        case (bus.cmd_op)
          OP_WR_PIX: if (x_ok && y_ok) begin
            rgb_addr_n  = pix_addr;
            rgb_wdata_n = bus.cmd_data[7:0];
            wren_rgb_n  = 1'b1;
          end
          OP_RD_PIX: begin
            if (x_ok && y_ok) rgb_addr_n = pix_addr;
            rd_oor_n = !(x_ok && y_ok);
            rd_pal_n = 1'b0;
            state_n  = RD_WAIT;
          end
          OP_WR_PAL: begin
            pal_addr_n  = bus.cmd_x[7:0];
            pal_wdata_n = bus.cmd_data;
            wren_pal_n  = 1'b1;
          end
          OP_RD_PAL: begin
            pal_addr_n = bus.cmd_x[7:0];
            rd_pal_n   = 1'b1;
            state_n    = RD_WAIT;
          end
          OP_FILL: begin
            if (!x_ok || !y_ok || w_eff == 9'd0 || h_eff == 8'd0) begin
              done_n = 1'b1;
            end else begin
              fill_w_n    = w_eff;
              fill_h_n    = h_eff;
              col_n       = '0;
              row_n       = '0;
              row_base_n  = pix_addr;
              fill_end_n  = 1'b0;
              rgb_wdata_n = bus.cmd_data[7:0];
              state_n     = bus.cmd_sync ? WAIT_VB : FILL;
            end
          end
          default: ;
        endcase
      end
      RD_WAIT: state_n = RD_CAP;
      RD_CAP: begin
        rsp_valid_n = 1'b1;
        rsp_data_n  = rd_pal ? pal_rdata : (rd_oor ? 24'h0 : {16'h0, rgb_rdata});
        state_n     = IDLE;
      end
      WAIT_VB: if (vblank && !vb_q) state_n = FILL;
      FILL: begin
        // Row base advances by one line per row so the loop needs only adders.
        if (fill_end) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          wren_rgb_n = 1'b1;
          rgb_addr_n = row_base + ADDR_W'(col);
          if (col == fill_w - 9'd1) begin
            col_n      = '0;
            row_n      = row + 8'd1;
            row_base_n = row_base + ADDR_W'(FRAME_WIDTH);
            if (row == fill_h - 8'd1) fill_end_n = 1'b1;
          end else begin
            col_n = col + 9'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fb_access_ctrl.sv
// Self-checking bench for fb_access_ctrl: an event-schedule model of the
// command timing plus literal spot checks of addresses and read data.
module tb_fb_access_ctrl;
  localparam int FW = 320;
  localparam int FH = 240;
  localparam int NPIX = FW * FH;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic vblank = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fb_access_ctrl_if bus();
  logic [16:0] rgb_addr;
  logic [7:0]  rgb_wdata, rgb_rdata, pal_addr;
  logic        wren_rgb, wren_pal;
  logic [23:0] pal_wdata, pal_rdata;
  logic [2:0]  state_dbg;

  fb_access_ctrl #(.FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .ADDR_W(17)) dut (
    .clk(clk), .reset(reset), .bus(bus), .vblank(vblank),
    .rgb_addr(rgb_addr), .rgb_wdata(rgb_wdata), .wren_rgb(wren_rgb), .rgb_rdata(rgb_rdata),
    .pal_addr(pal_addr), .pal_wdata(pal_wdata), .wren_pal(wren_pal), .pal_rdata(pal_rdata),
    .state_dbg(state_dbg)
  );

  // RAMs with registered read data
  logic [7:0]  fb_ram  [0:NPIX-1];
  logic [23:0] pal_ram [0:255];
  always @(posedge clk) begin
    if (rgb_addr < 17'(NPIX)) begin
      if (wren_rgb) fb_ram[rgb_addr] <= rgb_wdata;
      rgb_rdata <= fb_ram[rgb_addr];
    end else begin
      rgb_rdata <= 8'h0;
    end
    if (wren_pal) pal_ram[pal_addr] <= pal_wdata;
    pal_rdata <= pal_ram[pal_addr];
  end

  // model: expected events keyed by cycle number
  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit model_waiting = 1'b0;
  logic [16:0] exp_wr_addr  [int];
  logic [7:0]  exp_wr_data  [int];
  logic [7:0]  exp_pal_addr [int];
  logic [23:0] exp_pal_data [int];
  logic [23:0] exp_rsp      [int];
  bit          exp_done     [int];
  bit          exp_busy     [int];
  logic [7:0]  model_fb  [0:NPIX-1];
  logic [23:0] model_pal [0:255];

  // scoreboard: observed logs against literal expectation queues
  logic [16:0] exp_q[$];
  logic [23:0] exp_rsp_q[$];
  logic [16:0] obs_wr[$];
  logic [23:0] obs_rsp[$];
  int obs_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    int c;
    if (chk_en) begin
      c = cyc;
      check("cmd_ready", 32'(bus.cmd_ready), 32'(!(exp_busy.exists(c) || model_waiting)));
      check("wren_rgb", 32'(wren_rgb), 32'(exp_wr_addr.exists(c)));
      if (exp_wr_addr.exists(c)) begin
        check("rgb_addr", 32'(rgb_addr), 32'(exp_wr_addr[c]));
        check("rgb_wdata", 32'(rgb_wdata), 32'(exp_wr_data[c]));
        model_fb[exp_wr_addr[c]] = exp_wr_data[c];
      end
      check("wren_pal", 32'(wren_pal), 32'(exp_pal_addr.exists(c)));
      if (exp_pal_addr.exists(c)) begin
        check("pal_addr", 32'(pal_addr), 32'(exp_pal_addr[c]));
        check("pal_wdata", 32'(pal_wdata), 32'(exp_pal_data[c]));
        model_pal[exp_pal_addr[c]] = exp_pal_data[c];
      end
      check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp.exists(c)));
      if (exp_rsp.exists(c)) check("rsp_data", 32'(bus.rsp_data), 32'(exp_rsp[c]));
      check("done", 32'(bus.done), 32'(exp_done.exists(c)));
      if (wren_rgb) obs_wr.push_back(rgb_addr);
      if (bus.rsp_valid) obs_rsp.push_back(bus.rsp_data);
      if (bus.done) obs_done++;
    end
  end

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic plan_fill(input int e, input int s, input int x, input int y,
                           input int we, input int he, input logic [7:0] d);
    for (int k = e; k <= s + we * he; k++) exp_busy[k] = 1'b1;
    for (int r = 0; r < he; r++)
      for (int cc = 0; cc < we; cc++) begin
        exp_wr_addr[s + 1 + r * we + cc] = 17'((y + r) * FW + x + cc);
        exp_wr_data[s + 1 + r * we + cc] = d;
      end
    exp_done[s + we * he + 1] = 1'b1;
    model_waiting = 1'b0;
  endtask

  task automatic clear_from(input int r);
    for (int k = r; k < r + NPIX + 200; k++) begin
      exp_wr_addr.delete(k); exp_wr_data.delete(k); exp_pal_addr.delete(k);
      exp_pal_data.delete(k); exp_rsp.delete(k); exp_done.delete(k); exp_busy.delete(k);
    end
    model_waiting = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input int x, input int y, input int w, input int h,
                      input logic [23:0] data, input bit sync, output int e);
    int t;
    int we;
    int he;
    t = 0;
    while (!bus.cmd_ready && t < 300) begin @(posedge clk); #1; t++; end
    if (!bus.cmd_ready) begin
      check("ready_timeout", 32'(bus.cmd_ready), 32'd1);
      e = -1;
      return;
    end
    bus.cmd_op = op; bus.cmd_x = 9'(x); bus.cmd_y = 8'(y); bus.cmd_w = 9'(w);
    bus.cmd_h = 8'(h); bus.cmd_data = data; bus.cmd_sync = sync; bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    bus.cmd_valid = 1'b0;
    case (op)
      3'd0: if (x < FW && y < FH) begin
        exp_wr_addr[e] = 17'(y * FW + x);
        exp_wr_data[e] = data[7:0];
      end
      3'd1: begin
        exp_busy[e] = 1'b1; exp_busy[e + 1] = 1'b1;
        exp_rsp[e + 2] = (x < FW && y < FH) ? {16'h0, model_fb[y * FW + x]} : 24'h0;
      end
      3'd2: begin
        we = (x < FW) ? ((w < FW - x) ? w : FW - x) : 0;
        he = (y < FH) ? ((h < FH - y) ? h : FH - y) : 0;
        if (we == 0 || he == 0) exp_done[e] = 1'b1;
        else if (sync) model_waiting = 1'b1;
        else plan_fill(e, e, x, y, we, he, data[7:0]);
      end
      3'd3: begin exp_pal_addr[e] = 8'(x); exp_pal_data[e] = data; end
      3'd4: begin
        exp_busy[e] = 1'b1; exp_busy[e + 1] = 1'b1;
        exp_rsp[e + 2] = model_pal[x % 256];
      end
      default: ;
    endcase
  endtask

  task automatic check_logs(input string name);
    check({name, "_wr_count"}, 32'(obs_wr.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) if (i < obs_wr.size()) check({name, "_wr_addr"}, 32'(obs_wr[i]), 32'(exp_q[i]));
    check({name, "_rsp_count"}, 32'(obs_rsp.size()), 32'(exp_rsp_q.size()));
    foreach (exp_rsp_q[i]) if (i < obs_rsp.size()) check({name, "_rsp_data"}, 32'(obs_rsp[i]), 32'(exp_rsp_q[i]));
    obs_wr.delete(); obs_rsp.delete(); exp_q.delete(); exp_rsp_q.delete();
  endtask

  initial begin
    int e;
    int v;
    for (int i = 0; i < NPIX; i++) begin fb_ram[i] = 8'h0; model_fb[i] = 8'h0; end
    for (int i = 0; i < 256; i++) begin pal_ram[i] = 24'h0; model_pal[i] = 24'h0; end
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_x = '0; bus.cmd_y = '0;
    bus.cmd_w = '0; bus.cmd_h = '0; bus.cmd_data = '0; bus.cmd_sync = 1'b0;

    // reset state
    @(posedge clk); #1;
    chk_en = 1'b1;
    idle(2);
    reset = 1'b0;
    check("rst_rgb_addr", 32'(rgb_addr), 32'd0);
    check("rst_pal_addr", 32'(pal_addr), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);

    // pixel write then read back
    send(3'd0, 5, 2, 0, 0, 24'hAB, 1'b0, e);
    send(3'd1, 5, 2, 0, 0, 24'h0, 1'b0, e);
    idle(4);
    exp_q.push_back(17'd645); exp_rsp_q.push_back(24'h0000AB);
    check_logs("pix_rw");

    // palette write then read back
    send(3'd3, 7, 0, 0, 0, 24'h123456, 1'b0, e);
    send(3'd4, 7, 0, 0, 0, 24'h0, 1'b0, e);
    idle(4);
    check("pal_addr_hold", 32'(pal_addr), 32'd7);
    exp_rsp_q.push_back(24'h123456);
    check_logs("pal_rw");

    // back-to-back writes with out-of-range drops
    send(3'd0, 0, 0, 0, 0, 24'h01, 1'b0, e);
    send(3'd0, 319, 0, 0, 0, 24'h02, 1'b0, e);
    send(3'd0, 320, 0, 0, 0, 24'h03, 1'b0, e);
    send(3'd0, 0, 239, 0, 0, 24'h04, 1'b0, e);
    send(3'd0, 0, 240, 0, 0, 24'h05, 1'b0, e);
    send(3'd0, 319, 239, 0, 0, 24'h06, 1'b0, e);
    send(3'd1, 319, 0, 0, 0, 24'h0, 1'b0, e);
    idle(4);
    exp_q.push_back(17'd0); exp_q.push_back(17'd319);
    exp_q.push_back(17'd76480); exp_q.push_back(17'd76799);
    exp_rsp_q.push_back(24'h02);
    check_logs("b2b");

    // clipped corner fill
    obs_done = 0;
    send(3'd2, 318, 238, 5, 4, 24'h11, 1'b0, e);
    idle(10);
    check("corner_done_count", 32'(obs_done), 32'd1);
    exp_q.push_back(17'd76478); exp_q.push_back(17'd76479);
    exp_q.push_back(17'd76798); exp_q.push_back(17'd76799);
    send(3'd1, 319, 239, 0, 0, 24'h0, 1'b0, e);
    send(3'd1, 320, 0, 0, 0, 24'h0, 1'b0, e);
    send(3'd1, 0, 239, 0, 0, 24'h0, 1'b0, e);
    idle(4);
    exp_rsp_q.push_back(24'h11); exp_rsp_q.push_back(24'h0); exp_rsp_q.push_back(24'h04);
    check_logs("corner");

    // degenerate fills and unknown ops
    obs_done = 0;
    send(3'd2, 3, 3, 0, 5, 24'h55, 1'b0, e);
    send(3'd2, 400, 3, 4, 4, 24'h55, 1'b0, e);
    send(3'd5, 1, 1, 1, 1, 24'h55, 1'b0, e);
    send(3'd7, 1, 1, 1, 1, 24'h55, 1'b0, e);
    idle(4);
    check("degenerate_done_count", 32'(obs_done), 32'd2);
    check_logs("degenerate");

    // vblank-synchronised fill issued while vblank already high
    obs_done = 0;
    vblank = 1'b1;
    idle(2);
    send(3'd2, 10, 10, 3, 2, 24'h22, 1'b1, e);
    idle(5);
    vblank = 1'b0;
    idle(3);
    check("sync_no_early_writes", 32'(obs_wr.size()), 32'd0);
    vblank = 1'b1;
    v = cyc + 1;
    plan_fill(e, v, 10, 10, 3, 2, 8'h22);
    idle(12);
    vblank = 1'b0;
    check("sync_done_count", 32'(obs_done), 32'd1);
    exp_q.push_back(17'd3210); exp_q.push_back(17'd3211); exp_q.push_back(17'd3212);
    exp_q.push_back(17'd3530); exp_q.push_back(17'd3531); exp_q.push_back(17'd3532);
    check_logs("sync");

    // reset during a full-screen fill, at its 100th write
    obs_done = 0;
    send(3'd2, 0, 0, 320, 240, 24'h33, 1'b0, e);
    idle(100);
    reset = 1'b1;
    clear_from(e + 101);
    idle(1);
    reset = 1'b0;
    check("abort_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_wren", 32'(wren_rgb), 32'd0);
    check("abort_wr_count", 32'(obs_wr.size()), 32'd100);
    obs_wr.delete();
    idle(5);
    check("abort_no_done", 32'(obs_done), 32'd0);
    send(3'd0, 200, 5, 0, 0, 24'h77, 1'b0, e);
    send(3'd1, 200, 5, 0, 0, 24'h0, 1'b0, e);
    send(3'd1, 99, 0, 0, 0, 24'h0, 1'b0, e);
    send(3'd1, 100, 0, 0, 0, 24'h0, 1'b0, e);
    idle(4);
    exp_q.push_back(17'd1800);
    exp_rsp_q.push_back(24'h77); exp_rsp_q.push_back(24'h33); exp_rsp_q.push_back(24'h0);
    check_logs("after_abort");

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
